word_scroller: RTL and testbench

//  Message buffer and scroll engine directly upstream of the per-digit letter decoders.

---
 rtl/word_pkg.sv | 15 +
 rtl/scroll_tick.sv | 37 +++
 rtl/word_scroller.sv | 147 ++++++++++++++
 tb/tb_word_scroller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/word_pkg.sv
// Shared constants and controller state encoding for the word scroller.
// Reused by the scroll controller and its bench.
package word_pkg;

   localparam logic [7:0] ASCII_SPACE      = 8'h20;
   localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_SCROLL = 2'd2,
      S_HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/scroll_tick.sv
// Scroll-step prescaler: counts TICK_DIV enabled cycles, emits a 1-cycle tick.
// A synchronous restart returns the phase to zero and suppresses the tick.
module scroll_tick #(
   parameter int TICK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && !restart_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/word_scroller.sv
// Message buffer and scroll engine feeding the per-digit letter decoders.
// Optional WORD_SCROLL_BLINK_EN: blink the static (HOLD) display every TICK_DIV cycles.
module word_scroller
   import word_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_DEPTH  = 16,
   parameter int TICK_DIV   = 4
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    Clear,
   input  logic                    WrValid,
   output logic                    WrReady,
   input  logic [7:0]              WrChar,
   input  logic                    WrLast,
   input  logic                    Pause,
   output logic [8*NUM_DIGITS-1:0] Chars,
   output logic                    Busy
);

   localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
   localparam int LW = $clog2(MSG_DEPTH + 1);
   localparam int PW = $clog2(MSG_DEPTH + 2 * NUM_DIGITS);

   state_e                  state_q, state_d;
   logic [7:0]              buf_q [MSG_DEPTH];
   logic [7:0]              buf_d [MSG_DEPTH];
   logic [LW-1:0]           wr_idx_q, wr_idx_d;
   logic [LW-1:0]           len_q, len_d;
   logic [PW-1:0]           pos_q, pos_d;
   logic [8*NUM_DIGITS-1:0] chars_q, chars_d;
   logic                    blink_q, blink_d;

   logic                    wr_fire, last_beat, restart, tick_en, tick;
   logic [LW-1:0]           wr_inc;
   logic [PW-1:0]           l_q, l_d, idx;
   logic [8*NUM_DIGITS-1:0] win;

   assign WrReady   = ((state_q == S_IDLE) || (state_q == S_LOAD)) &&
                      (wr_idx_q < LW'(MSG_DEPTH));
   assign Busy      = (state_q != S_IDLE);
   assign Chars     = chars_q;
   assign wr_fire   = WrValid && WrReady;
   assign wr_inc    = wr_idx_q + 1'b1;
   assign last_beat = WrLast || (wr_idx_q == LW'(MSG_DEPTH - 1));
   assign restart   = Clear || (wr_fire && last_beat);
   assign l_q       = PW'(len_q) + PW'(NUM_DIGITS);

`ifdef WORD_SCROLL_BLINK_EN
   assign tick_en = ((state_q == S_SCROLL) && !Pause) || (state_q == S_HOLD);
`else
   assign tick_en = (state_q == S_SCROLL) && !Pause;
`endif

   scroll_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk_i    (Clk),
      .rst_ni   (Rst_n),
      .en_i     (tick_en),
      .restart_i(restart),
      .tick_o   (tick)
   );

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      wr_idx_d = wr_idx_q;
      len_d    = len_q;
      pos_d    = pos_q;
      blink_d  = blink_q;
      if (Clear) begin
         state_d  = S_IDLE;
         wr_idx_d = '0;
         len_d    = '0;
         pos_d    = '0;
         blink_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_LOAD: begin
               if (wr_fire) begin
                  buf_d[wr_idx_q[AW-1:0]] = WrChar;
                  wr_idx_d = wr_inc;
                  state_d  = S_LOAD;
                  if (last_beat) begin
                     len_d   = wr_inc;
                     pos_d   = '0;
                     blink_d = 1'b0;
                     state_d = (PW'(wr_inc) > PW'(NUM_DIGITS)) ?
                               S_SCROLL : S_HOLD;
                  end
               end
            end
            S_SCROLL: begin
               if (tick) begin
                  pos_d = (pos_q + 1'b1 == l_q) ? '0 : pos_q + 1'b1;
               end
            end
            S_HOLD: begin
`ifdef WORD_SCROLL_BLINK_EN
               if (tick) blink_d = ~blink_q;
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Window over message + NUM_DIGITS trailing spaces; pos 0 doubles as HOLD view.
   always_comb begin
      l_d = PW'(len_d) + PW'(NUM_DIGITS);
      idx = '0;
      win = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         idx = pos_d + PW'(i);
         if (idx >= l_d) idx = idx - l_d;
         win[8*(NUM_DIGITS-1-i) +: 8] = (idx < PW'(len_d)) ?
                                        buf_d[idx[AW-1:0]] : ASCII_SPACE;
      end
      chars_d = {NUM_DIGITS{ASCII_SPACE}};
      if (((state_d == S_SCROLL) || (state_d == S_HOLD)) && !blink_d) begin
         chars_d = win;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= S_IDLE;
         wr_idx_q <= '0;
         len_q    <= '0;
         pos_q    <= '0;
         blink_q  <= 1'b0;
         chars_q  <= {NUM_DIGITS{ASCII_SPACE}};
         for (int i = 0; i < MSG_DEPTH; i++) buf_q[i] <= ASCII_SPACE;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         len_q    <= len_d;
         pos_q    <= pos_d;
         blink_q  <= blink_d;
         chars_q  <= chars_d;
         for (int i = 0; i < MSG_DEPTH; i++) buf_q[i] <= buf_d[i];
      end
   end

endmodule

// File: tb/tb_word_scroller.sv
// Bench for word_scroller: directed writes with a scoreboard of expected
// display windows and change spacing, popped by an independent monitor.
module tb_word_scroller;
   import word_pkg::*;

   typedef struct {
      logic [31:0] val;
      int          gap;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst_n, Clear, WrValid, WrLast, Pause;
   logic        WrReady, Busy;
   logic [7:0]  WrChar;
   logic [31:0] Chars;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_chg = 0;
   bit          mon_en = 1'b0;
   logic [31:0] prev = 32'h20202020;
   exp_t        q[$];
   exp_t        e;

   word_scroller #(
      .NUM_DIGITS(4),
      .MSG_DEPTH (16),
      .TICK_DIV  (4)
   ) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Clear  (Clear),
      .WrValid(WrValid),
      .WrReady(WrReady),
      .WrChar (WrChar),
      .WrLast (WrLast),
      .Pause  (Pause),
      .Chars  (Chars),
      .Busy   (Busy)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   always @(negedge Clk) begin
      if (mon_en && (Chars !== prev)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL chars_unexpected: got %h required no change from %h",
                     Chars, prev);
         end else begin
            e = q.pop_front();
            if (Chars !== e.val || (e.gap != 0 && cyc - last_chg != e.gap)) begin
               errors++;
               $display("FAIL chars_window: got %h after %0d clks required %h after %0d",
                        Chars, cyc - last_chg, e.val, e.gap);
            end
         end
         prev     = Chars;
         last_chg = cyc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] v, input int g);
      exp_t x;
      x.val = v;
      x.gap = g;
      q.push_back(x);
   endtask

   task automatic beat(input logic [7:0] c, input logic l);
      WrValid = 1'b1;
      WrChar  = c;
      WrLast  = l;
      @(negedge Clk);
      WrValid = 1'b0;
      WrLast  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n = 1'b0; Clear = 1'b0; WrValid = 1'b0;
      WrChar = 8'h00; WrLast = 1'b0; Pause = 1'b0;
      repeat (2) @(negedge Clk);
      chk("reset_chars", Chars, 32'h20202020);
      chk("reset_ready", {31'd0, WrReady}, 32'd1);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      prev = Chars; last_chg = cyc; mon_en = 1'b1;

      // "HELLO": L = 9, one full revolution then pause and clear
      push(32'h48454C4C, 0);
      push(32'h454C4C4F, 4);
      push(32'h4C4C4F20, 4);
      push(32'h4C4F2020, 4);
      push(32'h4F202020, 4);
      push(32'h20202020, 4);
      push(32'h20202048, 4);
      push(32'h20204845, 4);
      push(32'h2048454C, 4);
      push(32'h48454C4C, 4);
      push(32'h454C4C4F, 14);
      push(32'h20202020, 1);
      beat(8'h48, 1'b0);
      beat(8'h45, 1'b0);
      beat(8'h4C, 1'b0);
      beat(8'h4C, 1'b0);
      beat(8'h4F, 1'b1);
      chk("scroll_busy", {31'd0, Busy}, 32'd1);
      chk("scroll_ready", {31'd0, WrReady}, 32'd0);
      repeat (37) @(negedge Clk);
      Pause = 1'b1;
      repeat (10) @(negedge Clk);
      Pause = 1'b0;
      repeat (3) @(negedge Clk);
      Clear = 1'b1; WrValid = 1'b1; WrChar = 8'h5A;
      @(negedge Clk);
      Clear = 1'b0; WrValid = 1'b0;
      chk("clear_busy", {31'd0, Busy}, 32'd0);
      chk("clear_ready", {31'd0, WrReady}, 32'd1);

      // "Ab": static HOLD, late write ignored
      push(32'h41422020, 0);
`ifdef WORD_SCROLL_BLINK_EN
      for (int i = 0; i < 25; i++)
         push((i % 2 == 0) ? 32'h20202020 : 32'h41422020, 4);
`else
      push(32'h20202020, 0);
`endif
      beat(8'h41, 1'b0);
      beat(8'h42, 1'b1);
      chk("hold_busy", {31'd0, Busy}, 32'd1);
      chk("hold_ready", {31'd0, WrReady}, 32'd0);
      beat(8'h43, 1'b0);
      repeat (100) @(negedge Clk);
      Clear = 1'b1;
      @(negedge Clk);
      Clear = 1'b0;
      @(negedge Clk);

      // 16 beats without WrLast fill the buffer and start scrolling
      push(32'h61626364, 0);
      push(32'h62636465, 4);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("fill_ready15", {31'd0, WrReady}, 32'd1);
         beat(8'h61 + 8'(i), 1'b0);
      end
      chk("full_ready", {31'd0, WrReady}, 32'd0);
      chk("full_busy", {31'd0, Busy}, 32'd1);
      beat(8'h58, 1'b1);
      repeat (5) @(negedge Clk);
      push(32'h20202020, 0);
      #2 Rst_n = 1'b0;
      #1;
      chk("async_chars", Chars, 32'h20202020);
      chk("async_ready", {31'd0, WrReady}, 32'd1);
      chk("async_busy", {31'd0, Busy}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
